// File: rtl/sit9122_oe_monitor.sv
// SiT9122 OE_ST sequencer and frequency-window monitor, all on the system clock.
// Build option SIT9122_AUTO_RETRY_EN: a bad window power-cycles the oscillator through RETRY.
module sit9122_oe_monitor #(
   parameter bit OE_ACTIVE_HIGH = 1'b1,
   parameter int STARTUP_CYCLES = 1000,
   parameter int GATE_CYCLES    = 4096,
   parameter int CNT_W          = 16,
   parameter int CNT_MIN        = 1000,
   parameter int CNT_MAX        = 1100,
   parameter int GOOD_WINDOWS   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             fault_clr,
   input  logic             osc_toggle,
   output logic             oe_st,
   output logic [CNT_W-1:0] osc_cnt,
   output logic             cnt_valid,
   output logic             clk_ok,
   output logic             fault,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      ST_OFF     = 2'd0,
      ST_STARTUP = 2'd1,
      ST_MEASURE = 2'd2,
      ST_RETRY   = 2'd3
   } state_t;

   localparam int WAIT_W = $clog2(STARTUP_CYCLES + 1);
   localparam int GATE_W = $clog2(GATE_CYCLES + 1);
   localparam int STRK_W = $clog2(GOOD_WINDOWS + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STARTUP_CYCLES - 1);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [STRK_W-1:0] STRK_FULL = STRK_W'(GOOD_WINDOWS);
   localparam logic [CNT_W-1:0]  CNT_SAT   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_LO    = CNT_W'(CNT_MIN);
   localparam logic [CNT_W-1:0]  CNT_HI    = CNT_W'(CNT_MAX);
   localparam logic              OE_ON     = OE_ACTIVE_HIGH;
   localparam logic              OE_OFF    = ~OE_ACTIVE_HIGH;

   state_t              state_r;
   state_t              state_nxt_s;
   logic                sync1_r;
   logic                sync2_r;
   logic                sync3_r;
   logic [WAIT_W-1:0]   wait_cnt_r;
   logic [GATE_W-1:0]   gate_cnt_r;
   logic [CNT_W-1:0]    edge_cnt_r;
   logic [STRK_W-1:0]   streak_r;
   logic                oe_st_r;
   logic [CNT_W-1:0]    osc_cnt_r;
   logic                cnt_valid_r;
   logic                clk_ok_r;
   logic                fault_r;

   logic                osc_edge_s;
   logic [CNT_W-1:0]    cnt_total_s;
   logic                in_range_s;
   logic                win_end_s;
   logic                wait_done_s;
   logic [STRK_W-1:0]   streak_inc_s;

   // Window arithmetic: the count closing a window includes an edge seen on its last cycle.
   always_comb begin
      osc_edge_s = sync2_r ^ sync3_r;
      if (edge_cnt_r == CNT_SAT) begin
         cnt_total_s = CNT_SAT;
      end else begin
         cnt_total_s = edge_cnt_r + {{(CNT_W-1){1'b0}}, osc_edge_s};
      end
      in_range_s  = (cnt_total_s >= CNT_LO) && (cnt_total_s <= CNT_HI);
      win_end_s   = enable && (state_r == ST_MEASURE) && (gate_cnt_r == GATE_LAST);
      wait_done_s = (wait_cnt_r == WAIT_LAST);
      if (streak_r == STRK_FULL) begin
         streak_inc_s = STRK_FULL;
      end else begin
         streak_inc_s = streak_r + STRK_W'(1);
      end
   end

   // Next-state logic; dropping enable overrides everything, including a window end.
   always_comb begin
      state_nxt_s = state_r;
      if (!enable) begin
         state_nxt_s = ST_OFF;
      end else begin
         case (state_r)
            ST_OFF: state_nxt_s = ST_STARTUP;
            ST_STARTUP: begin
               if (wait_done_s) begin
                  state_nxt_s = ST_MEASURE;
               end else begin
                  state_nxt_s = ST_STARTUP;
               end
            end
            ST_MEASURE: begin
               if (win_end_s && !in_range_s) begin
`ifdef SIT9122_AUTO_RETRY_EN
                  state_nxt_s = ST_RETRY;
`else
                  state_nxt_s = ST_MEASURE;
`endif
               end else begin
                  state_nxt_s = ST_MEASURE;
               end
            end
            ST_RETRY: begin
`ifdef SIT9122_AUTO_RETRY_EN
               if (wait_done_s) begin
                  state_nxt_s = ST_STARTUP;
               end else begin
                  state_nxt_s = ST_RETRY;
               end
`else
               state_nxt_s = ST_OFF;
`endif
            end
            default: state_nxt_s = ST_OFF;
         endcase
      end
   end

   // State register, oscillator-toggle synchroniser and phase/window counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= ST_OFF;
         sync1_r    <= 1'b0;
         sync2_r    <= 1'b0;
         sync3_r    <= 1'b0;
         wait_cnt_r <= '0;
         gate_cnt_r <= '0;
         edge_cnt_r <= '0;
      end else begin
         state_r <= state_nxt_s;
         sync1_r <= osc_toggle;
         sync2_r <= sync1_r;
         sync3_r <= sync2_r;
         if ((state_nxt_s == state_r) && ((state_r == ST_STARTUP) || (state_r == ST_RETRY))) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
         end else begin
            wait_cnt_r <= '0;
         end
         // Back-to-back windows: counters restart on the closing cycle itself.
         if ((state_r == ST_MEASURE) && (state_nxt_s == ST_MEASURE) && !win_end_s) begin
            gate_cnt_r <= gate_cnt_r + GATE_W'(1);
            edge_cnt_r <= cnt_total_s;
         end else begin
            gate_cnt_r <= '0;
            edge_cnt_r <= '0;
         end
      end
   end

   // Registered status outputs: pin drive, window result, good streak and sticky fault.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         oe_st_r     <= OE_OFF;
         osc_cnt_r   <= '0;
         cnt_valid_r <= 1'b0;
         streak_r    <= '0;
         clk_ok_r    <= 1'b0;
         fault_r     <= 1'b0;
      end else begin
         if ((state_nxt_s == ST_STARTUP) || (state_nxt_s == ST_MEASURE)) begin
            oe_st_r <= OE_ON;
         end else begin
            oe_st_r <= OE_OFF;
         end
         cnt_valid_r <= win_end_s;
         if (win_end_s) begin
            osc_cnt_r <= cnt_total_s;
         end else begin
            osc_cnt_r <= osc_cnt_r;
         end
         if (state_nxt_s != ST_MEASURE) begin
            streak_r <= '0;
            clk_ok_r <= 1'b0;
         end else if (win_end_s) begin
            streak_r <= in_range_s ? streak_inc_s : '0;
            clk_ok_r <= in_range_s && (streak_inc_s == STRK_FULL);
         end else begin
            streak_r <= streak_r;
            clk_ok_r <= clk_ok_r;
         end
         if (win_end_s && !in_range_s) begin
            fault_r <= 1'b1;
         end else if (fault_clr) begin
            fault_r <= 1'b0;
         end else begin
            fault_r <= fault_r;
         end
      end
   end

   assign oe_st     = oe_st_r;
   assign osc_cnt   = osc_cnt_r;
   assign cnt_valid = cnt_valid_r;
   assign clk_ok    = clk_ok_r;
   assign fault     = fault_r;
   assign state     = state_r;

endmodule

// File: tb/tb_sit9122_oe_monitor.sv
// Bench for sit9122_oe_monitor: directed scenarios plus random stimulus, checked every
// cycle against a window-arithmetic reference model. Honours SIT9122_AUTO_RETRY_EN.
module tb_sit9122_oe_monitor;

   localparam int STARTUP = 16;
   localparam int GATE    = 64;
   localparam int CMIN    = 30;
   localparam int CMAX    = 34;
   localparam int GOOD    = 2;
   localparam int PAT     = 64;
`ifdef SIT9122_AUTO_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif
   localparam int BAD_PERIOD = RETRY_EN ? (2 * STARTUP + GATE) : GATE;
   localparam int M_OFF = 0, M_START = 1, M_MEAS = 2, M_RETRY = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        fault_clr = 1'b0;
   logic        osc_toggle = 1'b0;
   logic        oe_st;
   logic [15:0] osc_cnt;
   logic        cnt_valid;
   logic        clk_ok;
   logic        fault;
   logic [1:0]  state;

   sit9122_oe_monitor #(
      .OE_ACTIVE_HIGH(1'b1), .STARTUP_CYCLES(STARTUP), .GATE_CYCLES(GATE), .CNT_W(16),
      .CNT_MIN(CMIN), .CNT_MAX(CMAX), .GOOD_WINDOWS(GOOD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .fault_clr(fault_clr),
      .osc_toggle(osc_toggle), .oe_st(oe_st), .osc_cnt(osc_cnt), .cnt_valid(cnt_valid),
      .clk_ok(clk_ok), .fault(fault), .state(state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int rate     = 0;   // toggle flips per 64 clk cycles
   int tcnt     = 0;
   int cyc      = 0;
   bit s_h [0:65535];  // toggle value as sampled at each posedge (0 while in reset)
   int m_mode = M_OFF, m_t0 = 0, m_osc = 0, m_streak = 0, m_cnt = 0;
   bit m_valid = 1'b0, m_ok = 1'b0, m_fault = 1'b0, m_oe = 1'b0;
   int rates_tbl [9] = '{0, 29, 30, 31, 32, 33, 34, 35, 64};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: at the falling edge, advance the evenly spread toggle pattern.
   task automatic step();
      @(negedge clk);
      if (((tcnt * rate) % PAT) < rate) osc_toggle = ~osc_toggle;
      tcnt++;
   endtask

   task automatic wait_valid(input int max_cyc);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         step();
         if (cnt_valid === 1'b1) seen = 1'b1;
      end
      check("valid_seen", 32'(seen), 32'd1);
   endtask

   task automatic pulse_clr();
      fault_clr = 1'b1;
      step();
      fault_clr = 1'b0;
   endtask

   // A toggle change sampled at posedge k-2 reaches the counter at posedge k.
   function automatic int edge_at(input int k);
      if (k < 3) return 0;
      return (s_h[k-2] != s_h[k-3]) ? 1 : 0;
   endfunction

   // Reference model: phase timing by elapsed cycles, window count by summing edges.
   always @(posedge clk) begin
      s_h[cyc] = rst_n ? osc_toggle : 1'b0;
      if (!rst_n) begin
         m_mode = M_OFF; m_osc = 0; m_valid = 1'b0; m_ok = 1'b0; m_fault = 1'b0; m_streak = 0;
      end else begin
         m_valid = 1'b0;
         if (fault_clr) m_fault = 1'b0;
         if (!enable) begin
            m_mode = M_OFF; m_ok = 1'b0; m_streak = 0;
         end else if (m_mode == M_OFF) begin
            m_mode = M_START; m_t0 = cyc;
         end else if (m_mode == M_START || m_mode == M_RETRY) begin
            if (cyc - m_t0 == STARTUP) begin
               m_mode = (m_mode == M_START) ? M_MEAS : M_START;
               m_t0 = cyc;
            end
         end else if (cyc - m_t0 == GATE) begin
            m_cnt = 0;
            for (int k = m_t0 + 1; k <= cyc; k++) m_cnt += edge_at(k);
            m_osc = m_cnt; m_valid = 1'b1;
            if (m_cnt >= CMIN && m_cnt <= CMAX) begin
               m_streak = (m_streak < GOOD) ? m_streak + 1 : GOOD;
               m_ok = (m_streak == GOOD);
            end else begin
               m_streak = 0; m_ok = 1'b0; m_fault = 1'b1;
               if (RETRY_EN) m_mode = M_RETRY;
            end
            m_t0 = cyc;
         end
      end
      m_oe = (m_mode == M_START || m_mode == M_MEAS);
      cyc++;
      #1;
      check($sformatf("cycle%0d", cyc - 1),
            {10'd0, state, oe_st, cnt_valid, clk_ok, fault, osc_cnt},
            {10'd0, 2'(m_mode), m_oe, m_valid, m_ok, m_fault, 16'(m_osc)});
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r, sel, dur;
      bit bad;
      // Reset held with enable asserted
      rst_n = 1'b0; enable = 1'b1; rate = 32;
      repeat (4) step();
      check("rst_oe", 32'(oe_st), 32'd0);
      check("rst_state", 32'(state), 32'd0);
      check("rst_osc_cnt", 32'(osc_cnt), 32'd0);
      check("rst_valid", 32'(cnt_valid), 32'd0);
      check("rst_ok", 32'(clk_ok), 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      rst_n = 1'b1;
      step();
      check("start_state", 32'(state), 32'd1);
      check("start_oe", 32'(oe_st), 32'd1);
      repeat (15) step();
      check("startup_len", 32'(state), 32'd1);
      step();
      check("measure_entry", 32'(state), 32'd2);

      // Nominal oscillator: 32 edges per window
      wait_valid(100);
      check("nom_cnt1", 32'(osc_cnt), 32'd32);
      check("nom_ok1", 32'(clk_ok), 32'd0);
      wait_valid(100);
      check("nom_cnt2", 32'(osc_cnt), 32'd32);
      check("nom_ok2", 32'(clk_ok), 32'd1);
      wait_valid(100);
      check("nom_ok3", 32'(clk_ok), 32'd1);
      check("nom_fault", 32'(fault), 32'd0);

      // Dead oscillator
      rate = 0;
      repeat (4) step();
      wait_valid(300);
      wait_valid(300);
      check("dead_cnt", 32'(osc_cnt), 32'd0);
      check("dead_fault", 32'(fault), 32'd1);
      check("dead_ok", 32'(clk_ok), 32'd0);
`ifdef SIT9122_AUTO_RETRY_EN
      check("retry_state", 32'(state), 32'd3);
      check("retry_oe", 32'(oe_st), 32'd0);
`endif
      pulse_clr();
      check("fault_clr", 32'(fault), 32'd0);
`ifdef SIT9122_AUTO_RETRY_EN
      repeat (14) step();
      check("retry_len_state", 32'(state), 32'd3);
      check("retry_len_oe", 32'(oe_st), 32'd0);
      step();
      check("retry_exit_state", 32'(state), 32'd1);
      check("retry_exit_oe", 32'(oe_st), 32'd1);
`endif

      // Fast and boundary edge counts
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: r = 64;
            1: r = 30;
            2: r = 34;
            3: r = 29;
            default: r = 35;
         endcase
         bad = (r < CMIN) || (r > CMAX);
         rate = r;
         repeat (4) step();
         wait_valid(300);
         pulse_clr();
         wait_valid(300);
         check($sformatf("bnd_cnt_%0d", r), 32'(osc_cnt), 32'(r));
         check($sformatf("bnd_fault_%0d", r), 32'(fault), 32'(bad));
      end

      // Disable in the middle of a window
      rate = 32;
      repeat (4) step();
      wait_valid(300);
      wait_valid(300);
      repeat (40) step();
      enable = 1'b0;
      step();
      check("dis_state", 32'(state), 32'd0);
      check("dis_oe", 32'(oe_st), 32'd0);
      check("dis_ok", 32'(clk_ok), 32'd0);
      check("dis_valid", 32'(cnt_valid), 32'd0);
      check("dis_osc_cnt", 32'(osc_cnt), 32'd32);
      repeat (5) step();
      enable = 1'b1;
      step();
      check("reen_state", 32'(state), 32'd1);
      repeat (15) step();
      check("reen_len", 32'(state), 32'd1);
      step();
      check("reen_measure", 32'(state), 32'd2);

      // fault_clr on the same cycle as a bad window end
      rate = 0;
      repeat (4) step();
      wait_valid(300);
      wait_valid(300);
      repeat (BAD_PERIOD - 1) step();
      pulse_clr();
      check("sim_clr_valid", 32'(cnt_valid), 32'd1);
      check("sim_clr_fault", 32'(fault), 32'd1);

      // enable drop on a window-end cycle
      rate = 32;
      repeat (4) step();
      wait_valid(300);
      wait_valid(300);
      repeat (GATE - 1) step();
      enable = 1'b0;
      step();
      check("sim_dis_valid", 32'(cnt_valid), 32'd0);
      check("sim_dis_state", 32'(state), 32'd0);
      enable = 1'b1;

      // Random segments: rate changes, short enable drops, clears and resets
      for (int s = 0; s < 40; s++) begin
         sel = int'($urandom_range(0, 9));
         rate = (sel == 9) ? int'($urandom_range(0, 64)) : rates_tbl[sel];
         dur = int'($urandom_range(40, 300));
         for (int i = 0; i < dur; i++) begin
            enable    = ($urandom_range(0, 199) != 0);
            fault_clr = ($urandom_range(0, 99) == 0);
            rst_n     = ($urandom_range(0, 999) != 0);
            step();
         end
      end
      rst_n = 1'b1; enable = 1'b1; fault_clr = 1'b0;
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
